// File: rtl/matrix_mac_seq.sv
// matrix_mac_seq: owns port B of the A/B/C BRAMs and computes C = A x B with
// one signed 16x16 MAC per cycle, writing one 32-bit C element per result.
module matrix_mac_seq #(
   parameter int DIM    = 64,
   parameter int AW     = 12,
   parameter int RD_LAT = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start_in,
   input  logic [6:0]         size_in,
   output logic               busy_out,
   output logic               done_out,
   output logic [2:0][AW-1:0] addrb_out,
   output logic [2:2]         web_out,
   output logic [2:2][31:0]   dinb_out,
   input  logic [1:0][15:0]   doutb_in
);

   localparam int              WCW   = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
   localparam logic [7:0]      DIM_W = 8'(DIM);
   localparam logic [AW-1:0]   DIM_A = AW'(DIM);

   typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_WRITE, S_DONE} state_t;

   state_t              r_state, w_next;
   logic                r_armed;
   logic [6:0]          r_n, r_i, r_j, r_k;
   logic [WCW-1:0]      r_wcnt;
   logic [RD_LAT-1:0]   r_vld_p;
   logic signed [31:0]  r_acc;
   logic [AW-1:0]       r_addr_a, r_addr_b, r_addr_c;
   logic [31:0]         r_dinb;

   logic [6:0]          w_n_eff;
   logic                w_accept, w_issue, w_k_last, w_j_last, w_e_last;
   logic [AW-1:0]       w_addr_a, w_addr_b, w_addr_c;
   logic signed [31:0]  w_prod;

   // Sizes beyond the RAM geometry are clamped to DIM.
   assign w_n_eff  = ({1'b0, size_in} > DIM_W) ? DIM_W[6:0] : size_in;
   // r_armed blocks a start presented in the same cycle reset is released.
   assign w_accept = (r_state == S_IDLE) && start_in && r_armed;
   assign w_issue  = (r_state == S_ISSUE);
   assign w_k_last = (r_k == r_n - 7'd1);
   assign w_j_last = (r_j == r_n - 7'd1);
   assign w_e_last = w_j_last && (r_i == r_n - 7'd1);

   assign w_addr_a = AW'(r_i) * DIM_A + AW'(r_k);
   assign w_addr_b = AW'(r_k) * DIM_A + AW'(r_j);
   assign w_addr_c = AW'(r_i) * DIM_A + AW'(r_j);
   assign w_prod   = 32'($signed(doutb_in[0])) * 32'($signed(doutb_in[1]));

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (w_accept) w_next = (w_n_eff == 7'd0) ? S_DONE : S_ISSUE;
         S_ISSUE: if (w_k_last) w_next = S_WAIT;
         S_WAIT:  if (r_wcnt == WCW'(RD_LAT - 1)) w_next = S_WRITE;
         S_WRITE: w_next = w_e_last ? S_DONE : S_ISSUE;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_armed  <= 1'b0;
         r_n      <= '0;
         r_i      <= '0;
         r_j      <= '0;
         r_k      <= '0;
         r_wcnt   <= '0;
         r_vld_p  <= '0;
         r_acc    <= '0;
         r_addr_a <= '0;
         r_addr_b <= '0;
         r_addr_c <= '0;
         r_dinb   <= '0;
      end else begin
         r_state <= w_next;
         r_armed <= 1'b1;
         // Valid bit tracks each issued term through the BRAM read latency.
         r_vld_p <= (r_vld_p << 1) | RD_LAT'(w_issue);
         if (r_vld_p[RD_LAT-1]) r_acc <= r_acc + w_prod;
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_n   <= w_n_eff;
                  r_i   <= '0;
                  r_j   <= '0;
                  r_k   <= '0;
                  r_acc <= '0;
               end
            end
            S_ISSUE: begin
               r_addr_a <= w_addr_a;
               r_addr_b <= w_addr_b;
               r_k      <= r_k + 7'd1;
               r_wcnt   <= '0;
            end
            S_WAIT: r_wcnt <= r_wcnt + WCW'(1);
            S_WRITE: begin
               r_addr_c <= w_addr_c;
               r_dinb   <= r_acc;
               r_acc    <= '0;
               r_k      <= '0;
               if (w_j_last) begin
                  r_j <= '0;
                  r_i <= r_i + 7'd1;
               end else begin
                  r_j <= r_j + 7'd1;
               end
            end
            default: ;
         endcase
      end
   end

   // Live address/data during their own state, last value held otherwise.
   always_comb begin
      busy_out     = (r_state == S_ISSUE) || (r_state == S_WAIT) || (r_state == S_WRITE);
      done_out     = (r_state == S_DONE);
      web_out[2]   = (r_state == S_WRITE);
      addrb_out[0] = w_issue ? w_addr_a : r_addr_a;
      addrb_out[1] = w_issue ? w_addr_b : r_addr_b;
      addrb_out[2] = (r_state == S_WRITE) ? w_addr_c : r_addr_c;
      dinb_out[2]  = (r_state == S_WRITE) ? r_acc : r_dinb;
   end

endmodule

// File: tb/tb_matrix_mac_seq.sv
// Bench for matrix_mac_seq: BRAM port-B model around the DUT, results compared
// against a plain triple-loop matrix product.
module tb_matrix_mac_seq;

   localparam int DIM    = 16;
   localparam int AW     = 8;
   localparam int RD_LAT = 2;
   localparam int LIMIT  = 20000;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               start_in = 1'b0;
   logic [6:0]         size_in = '0;
   logic               busy_out, done_out;
   logic [2:0][AW-1:0] addrb_out;
   logic [2:2]         web_out;
   logic [2:2][31:0]   dinb_out;
   logic [1:0][15:0]   doutb_in;

   logic [15:0] memA [DIM*DIM];
   logic [15:0] memB [DIM*DIM];
   logic [AW-1:0] cur_a, cur_b;
   logic [AW-1:0] pa [RD_LAT];
   logic [AW-1:0] pb [RD_LAT];

   logic [AW-1:0] wq_a [$];
   logic [31:0]   wq_d [$];
   logic [AW-1:0] exp_a [$];
   logic [31:0]   exp_d [$];

   int total = 0;
   int bad = 0;
   int busy_cyc, done_cyc;
   logic tail_busy, tail_done;

   matrix_mac_seq #(.DIM(DIM), .AW(AW), .RD_LAT(RD_LAT)) dut (
      .clk(clk), .rst_n(rst_n), .start_in(start_in), .size_in(size_in),
      .busy_out(busy_out), .done_out(done_out), .addrb_out(addrb_out),
      .web_out(web_out), .dinb_out(dinb_out), .doutb_in(doutb_in)
   );

   always #5 clk = ~clk;

   // BRAM port-B read model: address seen in cycle t yields data in cycle t+RD_LAT.
   always @(negedge clk) begin
      cur_a = addrb_out[0];
      cur_b = addrb_out[1];
      if (rst_n && web_out[2]) begin
         wq_a.push_back(addrb_out[2]);
         wq_d.push_back(dinb_out[2]);
      end
   end
   always @(posedge clk) begin
      for (int s = RD_LAT - 1; s > 0; s--) begin
         pa[s] <= pa[s-1];
         pb[s] <= pb[s-1];
      end
      pa[0] <= cur_a;
      pb[0] <= cur_b;
   end
   assign doutb_in[0] = memA[pa[RD_LAT-1]];
   assign doutb_in[1] = memB[pb[RD_LAT-1]];

   task automatic fill_rand();
      for (int x = 0; x < DIM*DIM; x++) begin
         memA[x] = 16'($urandom);
         memB[x] = 16'($urandom);
      end
   endtask

   task automatic fill_const(input logic [15:0] a, input logic [15:0] b);
      for (int x = 0; x < DIM*DIM; x++) begin
         memA[x] = a;
         memB[x] = b;
      end
   endtask

   // Reference C = A x B, element order j fastest then i.
   task automatic build_exp(input int n);
      int s;
      exp_a.delete();
      exp_d.delete();
      for (int i = 0; i < n; i++)
         for (int j = 0; j < n; j++) begin
            s = 0;
            for (int k = 0; k < n; k++)
               s += int'($signed(memA[i*DIM+k])) * int'($signed(memB[k*DIM+j]));
            exp_a.push_back(AW'(i*DIM + j));
            exp_d.push_back(32'(s));
         end
   endtask

   task automatic run_op(input int size, input bit mid_start);
      wq_a.delete();
      wq_d.delete();
      @(negedge clk);
      start_in = 1'b1;
      size_in  = 7'(size);
      @(negedge clk);
      start_in = 1'b0;
      busy_cyc = 0;
      done_cyc = -1;
      for (int c = 0; c < LIMIT; c++) begin
         if (done_out) begin
            done_cyc = c;
            break;
         end
         if (busy_out) busy_cyc++;
         if (mid_start && c == 7) begin
            start_in = 1'b1;
            size_in  = 7'd5;
         end else begin
            start_in = 1'b0;
         end
         @(negedge clk);
      end
      if (mid_start) start_in = 1'b1;
      @(negedge clk);
      start_in  = 1'b0;
      tail_busy = busy_out;
      tail_done = done_out;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      total++;
      if (busy_out !== 1'b0 || done_out !== 1'b0 || web_out !== 1'b0 ||
          addrb_out !== '0 || dinb_out !== '0) begin
         bad++;
         $display("FAIL reset_outputs: busy=%b done=%b web=%b addr=%h din=%h, want all 0",
                  busy_out, done_out, web_out, addrb_out, dinb_out);
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_identity();
      int ea [4];
      int ed [4];
      ea = '{0, 1, DIM, DIM + 1};
      ed = '{1, 2, 3, 4};
      fill_const(16'd0, 16'd0);
      memA[0] = 16'd1; memA[1] = 16'd2; memA[DIM] = 16'd3; memA[DIM+1] = 16'd4;
      memB[0] = 16'd1; memB[DIM+1] = 16'd1;
      run_op(2, 1'b0);
      total++;
      if (done_cyc !== 20 || busy_cyc !== 20) begin
         bad++;
         $display("FAIL identity_timing: done=%0d busy=%0d, want 20/20", done_cyc, busy_cyc);
      end
      total++;
      if (wq_a.size() !== 4) begin
         bad++;
         $display("FAIL identity_count: got %0d writes, want 4", wq_a.size());
      end
      for (int e = 0; e < 4 && e < wq_a.size(); e++) begin
         total++;
         if (wq_a[e] !== AW'(ea[e]) || wq_d[e] !== 32'(ed[e])) begin
            bad++;
            $display("FAIL identity_w%0d: got @%0d=%0d, want @%0d=%0d", e, wq_a[e], wq_d[e], ea[e], ed[e]);
         end
      end
      total++;
      if (tail_done !== 1'b0 || tail_busy !== 1'b0) begin
         bad++;
         $display("FAIL identity_done_pulse: done=%b busy=%b after pulse, want 0/0", tail_done, tail_busy);
      end
   endtask

   task automatic test_neg();
      memA[0] = 16'hFFFD;
      memB[0] = 16'd7;
      run_op(1, 1'b0);
      total++;
      if (wq_a.size() !== 1 || wq_a[0] !== '0 || wq_d[0] !== 32'hFFFFFFEB) begin
         bad++;
         $display("FAIL neg_1x1: got %0d writes first @%0d=%h, want 1 write @0=ffffffeb",
                  wq_a.size(), wq_a.size() ? wq_a[0] : '0, wq_d.size() ? wq_d[0] : '0);
      end
      total++;
      if (done_cyc !== 1 * (1 + RD_LAT + 1)) begin
         bad++;
         $display("FAIL neg_timing: done=%0d, want %0d", done_cyc, 1 + RD_LAT + 1);
      end
   endtask

   task automatic test_random(input int n, input int size);
      fill_rand();
      build_exp(n);
      run_op(size, 1'b0);
      total++;
      if (done_cyc !== n*n*(n + RD_LAT + 1) || wq_a.size() !== exp_a.size()) begin
         bad++;
         $display("FAIL rand_n%0d_shape: done=%0d writes=%0d, want %0d/%0d",
                  n, done_cyc, wq_a.size(), n*n*(n + RD_LAT + 1), exp_a.size());
      end
      for (int e = 0; e < exp_a.size() && e < wq_a.size(); e++) begin
         total++;
         if (wq_a[e] !== exp_a[e] || wq_d[e] !== exp_d[e]) begin
            bad++;
            $display("FAIL rand_n%0d_w%0d: got @%0d=%h, want @%0d=%h", n, e, wq_a[e], wq_d[e], exp_a[e], exp_d[e]);
         end
      end
   endtask

   task automatic test_wrap();
      logic [31:0] want;
      want = 32'(64'(DIM) * 64'h3FFF0001);
      fill_const(16'h7FFF, 16'h7FFF);
      run_op(DIM, 1'b0);
      total++;
      if (wq_a.size() !== DIM*DIM || done_cyc !== DIM*DIM*(DIM + RD_LAT + 1)) begin
         bad++;
         $display("FAIL wrap_shape: writes=%0d done=%0d, want %0d/%0d",
                  wq_a.size(), done_cyc, DIM*DIM, DIM*DIM*(DIM + RD_LAT + 1));
      end
      for (int e = 0; e < wq_a.size(); e++) begin
         total++;
         if (wq_d[e] !== want || wq_a[e] !== AW'(e)) begin
            bad++;
            $display("FAIL wrap_w%0d: got @%0d=%h, want @%0d=%h", e, wq_a[e], wq_d[e], e, want);
         end
      end
   endtask

   task automatic test_mid_start();
      fill_rand();
      build_exp(3);
      run_op(3, 1'b1);
      total++;
      if (done_cyc !== 9*(3 + RD_LAT + 1) || wq_a.size() !== 9) begin
         bad++;
         $display("FAIL midstart_shape: done=%0d writes=%0d, want %0d/9", done_cyc, wq_a.size(), 9*(3 + RD_LAT + 1));
      end
      for (int e = 0; e < 9 && e < wq_a.size(); e++) begin
         total++;
         if (wq_a[e] !== exp_a[e] || wq_d[e] !== exp_d[e]) begin
            bad++;
            $display("FAIL midstart_w%0d: got @%0d=%h, want @%0d=%h", e, wq_a[e], wq_d[e], exp_a[e], exp_d[e]);
         end
      end
      total++;
      if (tail_busy !== 1'b0) begin
         bad++;
         $display("FAIL start_in_done_ignored: busy=%b, want 0", tail_busy);
      end
   endtask

   task automatic test_zero();
      run_op(0, 1'b0);
      total++;
      if (done_cyc !== 0 || busy_cyc !== 0 || wq_a.size() !== 0) begin
         bad++;
         $display("FAIL zero_size: done=%0d busy=%0d writes=%0d, want 0/0/0", done_cyc, busy_cyc, wq_a.size());
      end
   endtask

   task automatic test_reset_mid();
      int seen;
      int held;
      bit hit;
      fill_rand();
      wq_a.delete();
      wq_d.delete();
      @(negedge clk);
      start_in = 1'b1;
      size_in  = 7'd3;
      @(negedge clk);
      start_in = 1'b0;
      seen = 0;
      hit  = 1'b0;
      for (int c = 0; c < LIMIT && !hit; c++) begin
         if (web_out[2]) begin
            if (seen == 3) hit = 1'b1;
            else seen++;
         end
         if (!hit) @(negedge clk);
      end
      rst_n = 1'b0;
      #1;
      total++;
      if (!hit || web_out !== 1'b0 || busy_out !== 1'b0 || addrb_out !== '0 || dinb_out !== '0) begin
         bad++;
         $display("FAIL reset_in_write: hit=%b web=%b busy=%b addr=%h din=%h, want 1/0/0/0/0",
                  hit, web_out, busy_out, addrb_out, dinb_out);
      end
      held = wq_a.size();
      repeat (4) @(negedge clk);
      total++;
      if (wq_a.size() !== held) begin
         bad++;
         $display("FAIL reset_no_writes: writes=%0d, want %0d", wq_a.size(), held);
      end
      rst_n    = 1'b1;
      start_in = 1'b1;
      size_in  = 7'd2;
      @(negedge clk);
      start_in = 1'b0;
      repeat (2) @(negedge clk);
      total++;
      if (busy_out !== 1'b0) begin
         bad++;
         $display("FAIL start_at_release: busy=%b, want 0", busy_out);
      end
   endtask

   initial begin
      test_reset();
      test_identity();
      test_neg();
      test_random(3, 3);
      test_random(5, 5);
      test_wrap();
      test_mid_start();
      test_zero();
      test_random(DIM, 100);
      test_reset_mid();
      test_random(4, 4);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
